// File: rtl/pdp8_tt_pkg.sv
// rtl/pdp8_tt_pkg.sv - major-state codes, IOT pulse bit positions and decode helper for pdp8_tt_fifo
package pdp8_tt_pkg;

   localparam logic [3:0] F0 = 4'b0000;
   localparam logic [3:0] F1 = 4'b0001;
   localparam logic [3:0] F2 = 4'b0010;
   localparam logic [3:0] F3 = 4'b0011;

   localparam int IOT_SKIP = 0;
   localparam int IOT_CLR  = 1;
   localparam int IOT_XFER = 2;

   localparam logic IE_RESET = 1'b1;

   typedef struct packed {
      logic xfer;
      logic clr;
      logic skip;
   } iot_pulse_t;

   function automatic iot_pulse_t iot_decode(input logic [2:0] bits);
      iot_pulse_t p;
      p.skip = bits[IOT_SKIP];
      p.clr  = bits[IOT_CLR];
      p.xfer = bits[IOT_XFER];
      return p;
   endfunction

endpackage

// File: rtl/pdp8_tt_fifo_buf.sv
// rtl/pdp8_tt_fifo_buf.sv - synchronous FIFO with count/full/empty/head, one per direction
module pdp8_tt_fifo_buf #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [WIDTH-1:0]       o_head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   // Empty FIFO presents zero so nothing stale leaks onto the bus.
   assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pdp8_tt_fifo.sv
// rtl/pdp8_tt_fifo.sv - KL8E-style console keyboard/printer IOT device with RX/TX FIFOs; TT_IE_EN adds the KIE instruction
module pdp8_tt_fifo
   import pdp8_tt_pkg::*;
#(
   parameter logic [5:0] KBD_DEV  = 6'o03,
   parameter logic [5:0] TTY_DEV  = 6'o04,
   parameter int         CHAR_W   = 8,
   parameter int         RX_DEPTH = 4,
   parameter int         TX_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              iot,
   input  logic [3:0]        state,
   input  logic [11:0]       mb,
   input  logic [5:0]        io_select,
   input  logic [11:0]       io_data_in,
   output logic [11:0]       io_data_out,
   output logic              io_selected,
   output logic              io_data_avail,
   output logic              io_skip,
   output logic              io_interrupt,
   output logic [CHAR_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [CHAR_W-1:0] rx_data,
   input  logic              rx_valid
);

   logic                      w_iot_f1;
   logic                      w_kbd_sel;
   logic                      w_tty_sel;
   iot_pulse_t                w_pulse;
   logic                      w_kie;
   logic                      w_ie;
   logic                      w_kbd_flag;
   logic                      w_kbd_pop;
   logic                      w_kbd_read;
   logic                      w_tty_clr;
   logic                      w_tty_push;
   logic                      w_rx_drop;
   logic [11:0]               w_kbd_word;
   logic                      w_unused;

   logic [$clog2(RX_DEPTH):0] w_rx_count;
   logic                      w_rx_full;
   logic                      w_rx_empty;
   logic [CHAR_W-1:0]         w_rx_head;
   logic [$clog2(TX_DEPTH):0] w_tx_count;
   logic                      w_tx_full;
   logic                      w_tx_empty;

   logic                      r_tty_flag;
   logic                      r_overrun;

   // Decode is held off while reset is low so the bus sees a quiet device at once.
   assign w_iot_f1  = reset && iot && (state == F1);
   assign w_kbd_sel = w_iot_f1 && (io_select == KBD_DEV);
   assign w_tty_sel = w_iot_f1 && (io_select == TTY_DEV);
   assign w_pulse   = iot_decode(mb[2:0]);

`ifdef TT_IE_EN
   logic r_ie;

   assign w_kie = w_kbd_sel && w_pulse.skip && w_pulse.xfer && !w_pulse.clr;
   assign w_ie  = r_ie;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ie <= IE_RESET;
      end else if (w_kie) begin
         r_ie <= io_data_in[0];
      end
   end
`else
   assign w_kie = 1'b0;
   assign w_ie  = IE_RESET;
`endif

   assign w_kbd_flag = (w_rx_count != '0);
   assign w_kbd_pop  = w_kbd_sel && w_pulse.clr;
   assign w_kbd_read = w_kbd_sel && w_pulse.xfer && !w_kie;
   assign w_tty_clr  = w_tty_sel && w_pulse.clr;
   assign w_tty_push = w_tty_sel && w_pulse.xfer;
   // A full RX FIFO being popped this cycle still takes the incoming char.
   assign w_rx_drop  = rx_valid && w_rx_full && !w_kbd_pop;

   assign io_selected   = w_kbd_sel || w_tty_sel;
   assign io_data_avail = 1'b1;
   assign io_skip       = (w_kbd_sel && w_pulse.skip && !w_kie && w_kbd_flag) ||
                          (w_tty_sel && w_pulse.skip && r_tty_flag);
   assign io_interrupt  = w_ie && (w_kbd_flag || r_tty_flag);
   assign tx_valid      = !w_tx_empty;

   always_comb begin
      w_kbd_word              = '0;
      w_kbd_word[CHAR_W-1:0]  = w_rx_head;
      w_kbd_word[11]          = r_overrun;
      io_data_out             = io_data_in;
      if (w_kbd_sel && !w_kie) begin
         io_data_out = w_kbd_read ? w_kbd_word : '0;
      end
   end

   pdp8_tt_fifo_buf #(
      .WIDTH (CHAR_W),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (rx_valid),
      .i_data  (rx_data),
      .i_pop   (w_kbd_pop),
      .o_count (w_rx_count),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_head  (w_rx_head)
   );

   pdp8_tt_fifo_buf #(
      .WIDTH (CHAR_W),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .i_push  (w_tty_push),
      .i_data  (io_data_in[CHAR_W-1:0]),
      .i_pop   (tx_ready),
      .o_count (w_tx_count),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_head  (tx_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overrun <= 1'b0;
      end else if (w_rx_drop) begin
         r_overrun <= 1'b1;
      end else if (w_kbd_pop) begin
         r_overrun <= 1'b0;
      end
   end

   // Flag follows TX space as seen this cycle; an explicit clear takes priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_tty_flag <= 1'b0;
      end else if (w_tty_clr) begin
         r_tty_flag <= 1'b0;
      end else if (!w_tx_full) begin
         r_tty_flag <= 1'b1;
      end
   end

   assign w_unused = ^{mb[11:3], w_rx_empty, w_tx_count};

endmodule

// File: tb/tb_pdp8_tt_fifo.sv
// tb/tb_pdp8_tt_fifo.sv - directed self-checking bench for pdp8_tt_fifo
module tb_pdp8_tt_fifo;

   localparam logic [5:0] KBD = 6'o03;
   localparam logic [5:0] TTY = 6'o04;

   logic        clk = 1'b0;
   logic        reset;
   logic        iot;
   logic [3:0]  state;
   logic [11:0] mb;
   logic [5:0]  io_select;
   logic [11:0] io_data_in;
   logic [11:0] io_data_out;
   logic        io_selected;
   logic        io_data_avail;
   logic        io_skip;
   logic        io_interrupt;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        sk;
   logic [11:0] ac;

   pdp8_tt_fifo dut (
      .clk           (clk),
      .reset         (reset),
      .iot           (iot),
      .state         (state),
      .mb            (mb),
      .io_select     (io_select),
      .io_data_in    (io_data_in),
      .io_data_out   (io_data_out),
      .io_selected   (io_selected),
      .io_data_avail (io_data_avail),
      .io_skip       (io_skip),
      .io_interrupt  (io_interrupt),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rx_push(input logic [7:0] d);
      @(negedge clk);
      rx_data  = d;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic iot_op(input logic [5:0] dev, input logic [2:0] p, input logic [11:0] acin,
                         input logic rdy, input logic rxv, input logic [7:0] rxd,
                         output logic skp, output logic [11:0] aco);
      @(negedge clk);
      iot        = 1'b1;
      state      = 4'b0001;
      io_select  = dev;
      mb         = {3'o6, dev, p};
      io_data_in = acin;
      tx_ready   = rdy;
      rx_valid   = rxv;
      rx_data    = rxd;
      #2;
      skp = io_skip;
      aco = io_data_out;
      @(posedge clk);
      #1;
      iot       = 1'b0;
      state     = 4'b0000;
      mb        = '0;
      io_select = '0;
      tx_ready  = 1'b0;
      rx_valid  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; iot = 1'b0; state = 4'b0000; mb = '0; io_select = '0;
      io_data_in = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_avail", io_data_avail, 1'b1);
      chk("rst_txv", tx_valid, 1'b0);
      chk("rst_irq", io_interrupt, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      // Reset dropped in the middle of live traffic
      rx_push(8'h55);
      iot_op(TTY, 3'b110, 12'h041, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("pre_txv", tx_valid, 1'b1);
      @(negedge clk);
      iot = 1'b1; state = 4'b0001; io_select = KBD; mb = {3'o6, KBD, 3'b001}; io_data_in = 12'o1234;
      #2;
      chk("pre_skip", io_skip, 1'b1);
      reset = 1'b0;
      #1;
      chk("mid_sel", io_selected, 1'b0);
      chk("mid_skip", io_skip, 1'b0);
      chk("mid_txv", tx_valid, 1'b0);
      chk("mid_txd", tx_data, 8'h00);
      chk("mid_irq", io_interrupt, 1'b0);
      chk("mid_ac", io_data_out, 12'o1234);
      @(negedge clk);
      iot = 1'b0; state = 4'b0000; mb = '0; io_select = '0;
      reset = 1'b1;
      iot_op(KBD, 3'b001, 12'o7777, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("post_ksf", sk, 1'b0);
      chk("post_ac0", ac, 12'o0000);

      // Single character receive
      rx_push(8'h41);
      iot_op(KBD, 3'b001, 12'o0, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("ksf_a", sk, 1'b1);
      iot_op(KBD, 3'b110, 12'o7777, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("krb_a", ac, 12'o0101);
      iot_op(KBD, 3'b001, 12'o0, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("ksf_none", sk, 1'b0);

      // Overrun: fifth char dropped, sticky bit reported on first read only
      for (int i = 0; i < 5; i++) rx_push(8'h61 + 8'(i));
      for (int i = 0; i < 4; i++) begin
         iot_op(KBD, 3'b110, 12'o0, 1'b0, 1'b0, 8'h00, sk, ac);
         chk("krb_ovr", ac, (i == 0) ? 12'h861 : (12'h061 + 12'(i)));
      end
      iot_op(KBD, 3'b001, 12'o0, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("ksf_drain", sk, 1'b0);

      // Full RX FIFO: pop and push in the same cycle both succeed
      for (int i = 0; i < 4; i++) rx_push(8'h70 + 8'(i));
      iot_op(KBD, 3'b110, 12'o0, 1'b0, 1'b1, 8'h74, sk, ac);
      chk("krb_pp0", ac, 12'h070);
      for (int i = 0; i < 4; i++) begin
         iot_op(KBD, 3'b110, 12'o0, 1'b0, 1'b0, 8'h00, sk, ac);
         chk("krb_pp", ac, 12'h071 + 12'(i));
      end

      // TLS sequence with the uart stalled
      for (int i = 0; i < 4; i++) begin
         iot_op(TTY, 3'b110, 12'h030 + 12'(i), 1'b0, 1'b0, 8'h00, sk, ac);
         tick();
         iot_op(TTY, 3'b001, 12'o0, 1'b0, 1'b0, 8'h00, sk, ac);
         chk("tsf_tls", sk, (i < 3) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      chk("tx_head0", tx_data, 8'h30);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      chk("flag_pop0", io_interrupt, 1'b0);
      tick();
      chk("flag_pop1", io_interrupt, 1'b1);

      // Full TX FIFO: drop without pop, accept with simultaneous pop
      iot_op(TTY, 3'b110, 12'h034, 1'b0, 1'b0, 8'h00, sk, ac);
      iot_op(TTY, 3'b110, 12'h058, 1'b0, 1'b0, 8'h00, sk, ac);
      iot_op(TTY, 3'b110, 12'h035, 1'b1, 1'b0, 8'h00, sk, ac);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tx_drain_v", tx_valid, 1'b1);
         chk("tx_drain_d", tx_data, 8'h32 + 8'(i));
         tx_ready = 1'b1;
         @(posedge clk);
         #1;
         tx_ready = 1'b0;
      end
      chk("tx_empty", tx_valid, 1'b0);

      // Interrupt enable handling, with the printer flag held low by a full TX FIFO
      for (int i = 0; i < 4; i++) iot_op(TTY, 3'b110, 12'h040 + 12'(i), 1'b0, 1'b0, 8'h00, sk, ac);
      iot_op(TTY, 3'b010, 12'o0, 1'b0, 1'b0, 8'h00, sk, ac);
      tick();
      chk("irq_quiet", io_interrupt, 1'b0);
      rx_push(8'h42);
`ifdef TT_IE_EN
      iot_op(KBD, 3'b101, 12'o0000, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("kie_noskip", sk, 1'b0);
      chk("kie_irq0", io_interrupt, 1'b0);
      iot_op(KBD, 3'b001, 12'o0, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("kie_ksf", sk, 1'b1);
      iot_op(KBD, 3'b101, 12'o0001, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("kie_irq1", io_interrupt, 1'b1);
`else
      iot_op(KBD, 3'b101, 12'o7777, 1'b0, 1'b0, 8'h00, sk, ac);
      chk("6035_skip", sk, 1'b1);
      chk("6035_ac", ac, 12'h042);
      chk("6035_irq", io_interrupt, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
